// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding and width helpers for the PC unit
package pc_pkg;

   typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET} pc_sel_e;

   function automatic int log2(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_data,
   output logic         empty,
   output logic         full,
   output logic         overflow
);
   import pc_pkg::*;

   localparam int RAS_PTR_W = log2(DEPTH);
   localparam logic [RAS_PTR_W-1:0] ONE = 1;

   logic [W-1:0]         mem [DEPTH];
   logic [RAS_PTR_W-1:0] tp;
   logic [RAS_PTR_W:0]   cnt;

   assign top_data = mem[tp - ONE];
   assign empty    = (cnt == '0);
   assign full     = (cnt == (RAS_PTR_W+1)'(DEPTH));

   // tp is the next write slot; when full it also points at the oldest entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tp       <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         tp       <= tp + ONE;
         cnt      <= full ? cnt : cnt + 1'b1;
         overflow <= overflow | full;
      end else if (pop) begin
         tp       <= tp - ONE;
         cnt      <= cnt - 1'b1;
      end
   end

   // entry storage needs no reset; the count decides what is valid
   always_ff @(posedge clk) begin
      if (push) mem[tp] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register with seq/branch/jump/call/return select and RAS; PC_ALIGN_CHECK_EN adds the misalign flag
module pc_unit #(
   parameter int                 BUS_WIDTH    = 16,
   parameter int                 INC          = 4,
   parameter int                 RAS_DEPTH    = 4,
   parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 br_taken,
   input  logic [BUS_WIDTH-1:0] br_offset,
   input  logic                 jump,
   input  logic                 call,
   input  logic                 ret,
   input  logic [BUS_WIDTH-1:0] jump_target,
   output logic [BUS_WIDTH-1:0] pc,
   output logic [BUS_WIDTH-1:0] pc_plus_inc,
   output logic                 ras_empty,
   output logic                 ras_full,
   output logic                 ras_overflow,
   output logic                 ret_underflow,
   output logic                 misalign
);
   import pc_pkg::*;

   pc_sel_e              sel;
   logic [BUS_WIDTH-1:0] next_pc;
   logic [BUS_WIDTH-1:0] ras_top;
   logic                 push;
   logic                 pop;

   assign pc_plus_inc   = pc + BUS_WIDTH'(INC);
   assign push          = ~stall & (sel == SEL_CALL);
   assign pop           = ~stall & (sel == SEL_RET) & ~ras_empty;
   assign ret_underflow = rst_n & ~stall & (sel == SEL_RET) & ras_empty;

   // fixed priority: ret > call > jump > branch > sequential
   always_comb begin
      sel     = ret ? SEL_RET : call ? SEL_CALL : jump ? SEL_JMP : br_taken ? SEL_BR : SEL_SEQ;
      next_pc = (sel == SEL_RET)  ? (ras_empty ? pc_plus_inc : ras_top) :
                (sel == SEL_CALL || sel == SEL_JMP) ? jump_target :
                (sel == SEL_BR)   ? pc + br_offset : pc_plus_inc;
   end

   // PC register holds during stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc <= RESET_VECTOR;
      else if (!stall) pc <= next_pc;
   end

   pc_ras #(.W(BUS_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus_inc),
      .top_data  (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .overflow  (ras_overflow)
   );

`ifdef PC_ALIGN_CHECK_EN
   // flag the cycle after a non-stalled load of a PC that is not INC-aligned
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else        misalign <= ~stall & ((next_pc & BUS_WIDTH'(INC - 1)) != '0);
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit (default parameters)
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
   logic [15:0] br_offset = '0, jump_target = '0;
   logic [15:0] pc, pc_plus_inc;
   logic        ras_empty, ras_full, ras_overflow, ret_underflow, misalign;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [15:0] MIS = 16'd1;
`else
   localparam logic [15:0] MIS = 16'd0;
`endif

   pc_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .br_taken      (br_taken),
      .br_offset     (br_offset),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus_inc   (pc_plus_inc),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_overflow  (ras_overflow),
      .ret_underflow (ret_underflow),
      .misalign      (misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic flags(input logic e, input logic f, input logic o, input string tag);
      chk({15'd0, ras_empty},    {15'd0, e}, {tag, "_empty"});
      chk({15'd0, ras_full},     {15'd0, f}, {tag, "_full"});
      chk({15'd0, ras_overflow}, {15'd0, o}, {tag, "_ovf"});
   endtask

   // drive one cycle of controls, queue the expected PC, check it after the edge
   task automatic step(input logic st, input logic r, input logic c, input logic j, input logic b,
                       input logic [15:0] off, input logic [15:0] tgt,
                       input logic [15:0] exp_pc, input logic exp_uf, input string tag);
      stall = st; ret = r; call = c; jump = j; br_taken = b;
      br_offset = off; jump_target = tgt;
      exp_q.push_back(exp_pc);
      #1;
      chk({15'd0, ret_underflow}, {15'd0, exp_uf}, {tag, "_uf"});
      @(posedge clk);
      #1;
      chk(pc, exp_q.pop_front(), tag);
      stall = 0; ret = 0; call = 0; jump = 0; br_taken = 0;
   endtask

   task automatic free(input logic [15:0] exp_pc, input string tag);
      step(0, 0, 0, 0, 0, 16'h0, 16'h0, exp_pc, 0, tag);
   endtask

   initial begin
      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk(pc, 16'h0000, "rst_pc");
      flags(1, 0, 0, "rst");
      chk({15'd0, ret_underflow}, 16'd0, "rst_uf");
      chk({15'd0, misalign}, 16'd0, "rst_mis");
      rst_n = 1'b1;

      // sequential
      chk(pc_plus_inc, 16'h0004, "pinc0");
      free(16'h0004, "seq1");
      free(16'h0008, "seq2");
      free(16'h000C, "seq3");
      flags(1, 0, 0, "seq");

      // branch with negative offset, then jump beats branch
      free(16'h0010, "seq4");
      step(0, 0, 0, 0, 1, 16'hFFF8, 16'h0, 16'h0008, 0, "br_neg");
      step(0, 0, 0, 1, 1, 16'h0040, 16'h0100, 16'h0100, 0, "jmp_vs_br");
      chk(pc_plus_inc, 16'h0104, "pinc100");

      // call / return
      step(0, 0, 0, 1, 0, 16'h0, 16'h0020, 16'h0020, 0, "j20");
      step(0, 0, 1, 0, 0, 16'h0, 16'h0200, 16'h0200, 0, "call200");
      flags(0, 0, 0, "call1");
      free(16'h0204, "c_seq1");
      free(16'h0208, "c_seq2");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0024, 0, "ret24");
      flags(1, 0, 0, "ret1");

      // overflow: five calls into a four-deep stack
      step(0, 0, 0, 1, 0, 16'h0, 16'h0000, 16'h0000, 0, "j0");
      step(0, 0, 1, 0, 0, 16'h0, 16'h0010, 16'h0010, 0, "call_a");
      step(0, 0, 1, 0, 0, 16'h0, 16'h0020, 16'h0020, 0, "call_b");
      step(0, 0, 1, 0, 0, 16'h0, 16'h0030, 16'h0030, 0, "call_c");
      step(0, 0, 1, 0, 0, 16'h0, 16'h0040, 16'h0040, 0, "call_d");
      flags(0, 1, 0, "full4");
      step(0, 0, 1, 0, 0, 16'h0, 16'h0050, 16'h0050, 0, "call_e");
      flags(0, 1, 1, "ovf");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0044, 0, "pop44");
      flags(0, 0, 1, "pop1");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0034, 0, "pop34");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0024, 0, "pop24");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0014, 0, "pop14");
      flags(1, 0, 1, "drained");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0018, 1, "underflow");
      // call+ret with an empty stack: ret wins, underflow, no push
      step(0, 1, 1, 0, 0, 16'h0, 16'h0700, 16'h001C, 1, "call_ret");
      flags(1, 0, 1, "call_ret");

      // stall holds PC and RAS, suppresses underflow
      step(0, 0, 1, 0, 0, 16'h0, 16'h0300, 16'h0300, 0, "call300");
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0300, 0, "stall");
      flags(0, 0, 1, "stall");
      step(0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0020, 0, "ret_after_stall");
      step(1, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0020, 0, "stall_empty");

      // wraparound
      step(0, 0, 0, 1, 0, 16'h0, 16'hFFFC, 16'hFFFC, 0, "jFFFC");
      free(16'h0000, "wrap");

      // asynchronous reset in the middle of a cycle
      call = 1; jump_target = 16'h0500;
      #3 rst_n = 1'b0;
      #1;
      chk(pc, 16'h0000, "arst_pc");
      flags(1, 0, 0, "arst");
      call = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk(pc, 16'h0000, "arst_hold");

      // alignment flag
      step(0, 0, 0, 1, 0, 16'h0, 16'h0102, 16'h0102, 0, "j102");
      chk({15'd0, misalign}, MIS, "mis_set");
      step(0, 0, 0, 1, 0, 16'h0, 16'h0200, 16'h0200, 0, "j200");
      chk({15'd0, misalign}, 16'd0, "mis_clr");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle core. It holds the PC register and selects the next PC from one of five sources: sequential increment, PC-relative branch, absolute jump, call, or return. A small circular return-address stack (RAS) supports call/return. It replaces the separate pc register and +4 adder pairing.

Parameters:
BUS_WIDTH, 16, width of PC and all address buses
INC, 4, sequential step added to PC; must be a power of two
RAS_DEPTH, 4, return-address stack entries; must be a power of two and at least 2
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS unchanged this cycle
br_taken  in  1  take PC-relative branch
br_offset  in  BUS_WIDTH  signed branch offset, added to current PC
jump  in  1  absolute jump to jump_target
call  in  1  jump to jump_target and push pc+INC
ret  in  1  pop RAS into PC
jump_target  in  BUS_WIDTH  absolute target for jump and call
pc  out  BUS_WIDTH  current PC (registered)
pc_plus_inc  out  BUS_WIDTH  pc+INC (combinational)
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky: a push occurred while the RAS was full
ret_underflow  out  1  one-cycle pulse: ret occurred while the RAS was empty
misalign  out  1  see Optional Feature

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_VECTOR.
  - RAS count=0 and top pointer=0.
  - ras_empty=1, ras_full=0, ras_overflow=0, ret_underflow=0, misalign=0.
- Arithmetic: all sums are BUS_WIDTH bits, modulo 2^BUS_WIDTH, and wrap silently.
  - pc_plus_inc = pc+INC.
  - Branch target = pc+br_offset.
- Next-PC priority, evaluated every cycle:
  - stall: pc, RAS and sticky flags hold; ret_underflow=0. Control inputs are ignored, not queued.
  - ret: if RAS is non-empty, pc<=top entry, pop, count-1. If RAS is empty, pc<=pc+INC and ret_underflow=1 for that cycle.
  - call: pc<=jump_target and push pc+INC.
  - jump: pc<=jump_target.
  - br_taken: pc<=pc+br_offset.
  - None of the above: pc<=pc+INC.
- Simultaneous requests: the highest-priority request wins and all others are dropped.
  - call+ret: ret wins and no push occurs.
  - jump+br_taken: jump wins.
- Latency: one cycle. Inputs sampled at edge N appear on pc after edge N.
- Push when full: overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_overflow<=1 (sticky until reset).
- Pop after an overwrite returns the newest entries first. Entries older than the depth are lost.
- ras_empty and ras_full are decoded from the registered count; they are never both 1.
- Reset mid-operation: immediate; RAS contents are discarded.

Optional Feature:
Macro: PC_ALIGN_CHECK_EN
- Defined:
  - misalignment means the candidate next PC has nonzero bits in positions [log2(INC)-1:0].
  - misalign is registered. It is 1 in the cycle after a non-stalled update whose next PC is misaligned, else 0.
  - The PC still loads the misaligned value.
- Undefined: misalign is tied to 0 and no check logic is built.

Decomposition:
- Package pc_pkg holds:
  - next-PC select enumeration: SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET.
  - localparam helpers: RAS_PTR_W=log2(RAS_DEPTH), INC_LSB=log2(INC).
- Sub-module pc_ras holds the circular stack: push, pop, count, full/empty, overflow.
- pc_unit keeps the select decode, adders and PC register.

Test Plan:
1. Reset then 3 free cycles, RESET_VECTOR=0 -> pc sequence 0x0000, 0x0004, 0x0008, 0x000C; ras_empty=1.
2. pc=0x0010, br_taken, br_offset=0xFFF8 -> pc=0x0008. Next cycle jump and br_taken together with jump_target=0x0100 -> pc=0x0100 (jump wins).
3. pc=0x0020, call with target 0x0200; then 2 free cycles; then ret -> pc goes 0x0200, 0x0204, 0x0208, then 0x0024; ras_empty=1.
4. 5 calls with RAS_DEPTH=4 from pcs 0x0, 0x10, 0x20, 0x30, 0x40 (target=pc+0x10) -> ras_full=1, ras_overflow=1. 4 rets return 0x44, 0x34, 0x24, 0x14. A 5th ret -> ret_underflow pulses, pc=pc+4.
5. stall held 3 cycles during ret request at pc=0x0300 -> pc stays 0x0300 and the RAS is unchanged. Assert rst_n=0 mid-cycle -> pc=RESET_VECTOR immediately, flags cleared.
6. With PC_ALIGN_CHECK_EN, jump_target=0x0102 -> pc=0x0102 and misalign=1 for one cycle. Without the macro -> misalign stays 0.
